// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data-stage requests onto one single-port
// memory. One access is outstanding at a time. Data has priority, but a
// streak limit keeps a waiting fetch from being starved. A wait timeout
// aborts accesses the memory never acknowledges.
module mem_port_arbiter #(
  parameter int STREAK_MAX = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        if_stall,
  output logic        d_stall,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err
);

  localparam int SW = $clog2(STREAK_MAX + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state_reg, state_next;
  logic          grant_d_reg;
  logic          we_reg;
  logic [31:0]   addr_reg;
  logic [31:0]   wdata_reg;
  logic [31:0]   rdata_reg;
  logic          err_reg;
  logic [SW-1:0] streak_reg;
  logic [WW-1:0] wait_cnt_reg;

  logic pick_d;
  logic any_req;
  logic timed_out;
  logic in_access;
  logic done;

  // Data wins unless a fetch is also waiting and the data streak is used up.
  assign pick_d    = d_req && !(if_req && (streak_reg == SW'(STREAK_MAX)));
  assign any_req   = if_req || d_req;
  assign timed_out = (wait_cnt_reg == WW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; acks are only looked at while an access is in flight.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_req) state_next = ISSUE;
      ISSUE:   state_next = mem_ack ? DONE : WAIT;
      WAIT:    if (mem_ack || timed_out) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant latching, streak tracking, wait counting and read-data capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_d_reg  <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      err_reg      <= 1'b0;
      streak_reg   <= '0;
      wait_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            grant_d_reg  <= pick_d;
            we_reg       <= pick_d && d_we;
            addr_reg     <= pick_d ? d_addr : if_addr;
            wdata_reg    <= pick_d ? d_wdata : 32'd0;
            rdata_reg    <= '0;
            err_reg      <= 1'b0;
            wait_cnt_reg <= '0;
            if (pick_d && if_req) begin
              if (streak_reg != SW'(STREAK_MAX)) streak_reg <= streak_reg + 1'b1;
            end else begin
              streak_reg <= '0;
            end
          end
        end
        ISSUE: begin
          if (mem_ack) rdata_reg <= we_reg ? 32'd0 : mem_rdata;
        end
        WAIT: begin
          if (mem_ack) begin
            rdata_reg <= we_reg ? 32'd0 : mem_rdata;
          end else if (timed_out) begin
            err_reg   <= 1'b1;
            rdata_reg <= '0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_access = (state_reg == ISSUE) || (state_reg == WAIT);
  assign done      = (state_reg == DONE);

  assign mem_en    = (state_reg == ISSUE);
  assign mem_we    = in_access && we_reg;
  assign mem_addr  = in_access ? addr_reg : 32'd0;
  assign mem_wdata = in_access ? wdata_reg : 32'd0;

  assign if_ready  = done && !grant_d_reg;
  assign d_ready   = done && grant_d_reg;
  assign if_rdata  = if_ready ? rdata_reg : 32'd0;
  assign d_rdata   = d_ready ? rdata_reg : 32'd0;
  assign err       = done && err_reg;

  assign if_stall  = if_req && !if_ready;
  assign d_stall   = d_req && !d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a directed vector table,
// hand-written reset/priority sequences and randomized accesses predicted
// by a transaction-level model.
module tb_mem_port_arbiter;

  localparam int STREAK_MAX = 4;
  localparam int TIMEOUT    = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we, mem_ack;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_ready, d_ready, if_stall, d_stall, mem_en, mem_we, err;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  int checks = 0;
  int fails  = 0;
  int streak_m = 0;
  int txn = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.STREAK_MAX(STREAK_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .if_stall(if_stall), .d_stall(d_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  typedef struct {
    bit        ireq;
    bit [31:0] iaddr;
    bit        dreq;
    bit        dwe;
    bit [31:0] daddr;
    bit [31:0] dwdata;
    bit [31:0] mdata;
    int        lat;       // ack cycle counted from ISSUE (0 = ack in ISSUE)
    bit        drop;      // deassert requests right after the grant
    bit        exp_d;     // expected grantee is the data port
    bit        exp_err;
    bit [31:0] exp_rdata;
  } vec_t;

  vec_t vt [8];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_if_ready"}, if_ready, 0);
    chk({tag, "_d_ready"}, d_ready, 0);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic do_reset();
    if_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    reset = 1;
    step();
    check_quiet("reset");
    reset = 0;
    streak_m = 0;
  endtask

  // Performs one access starting from an IDLE cycle and returns in the
  // following IDLE cycle with requests deasserted.
  task automatic do_access(input vec_t v);
    int k;
    int lat_exp;
    logic [31:0] exp_addr;
    if_req = v.ireq; if_addr = v.iaddr;
    d_req = v.dreq; d_we = v.dwe; d_addr = v.daddr; d_wdata = v.dwdata;
    mem_rdata = v.mdata; mem_ack = 0;
    exp_addr = v.exp_d ? v.daddr : v.iaddr;
    step();
    chk("issue_mem_en", mem_en, 1);
    chk("issue_mem_addr", mem_addr, exp_addr);
    chk("issue_mem_we", mem_we, v.exp_d & v.dwe);
    if (v.exp_d && v.dwe) chk("issue_mem_wdata", mem_wdata, v.dwdata);
    if (v.drop) begin if_req = 0; d_req = 0; end
    for (k = 1; k <= 40; k++) begin
      mem_ack = (k - 1 == v.lat);
      step();
      mem_ack = 0;
      if (if_ready || d_ready) break;
      chk("wait_mem_en", mem_en, 0);
      chk("wait_mem_addr", mem_addr, exp_addr);
    end
    lat_exp = (v.lat <= TIMEOUT) ? v.lat + 1 : TIMEOUT + 1;
    chk("latency", k, lat_exp);
    chk("if_ready", if_ready, !v.exp_d);
    chk("d_ready", d_ready, v.exp_d);
    chk("rdata", v.exp_d ? d_rdata : if_rdata, v.exp_rdata);
    chk("err", err, v.exp_err);
    chk("grantee_stall", v.exp_d ? d_stall : if_stall, 0);
    $display("txn %0d: grant=%s addr=%h we=%0b lat=%0d cycles=%0d err=%0b rdata=%h",
             txn, v.exp_d ? "D" : "IF", exp_addr, v.exp_d & v.dwe, v.lat, k, err,
             v.exp_d ? d_rdata : if_rdata);
    txn++;
    step();
    chk("pulse_end", if_ready | d_ready | err, 0);
    chk("idle_mem_en", mem_en, 0);
    if_req = 0; d_req = 0;
    if (v.exp_d && v.ireq) streak_m = (streak_m < STREAK_MAX) ? streak_m + 1 : STREAK_MAX;
    else streak_m = 0;
    if (v.drop) repeat (2) begin
      step();
      chk("no_regrant", mem_en, 0);
    end
  endtask

  initial begin
    vec_t v;
    vt[0] = '{1, 32'h40, 0, 0, 32'h0,   32'h0,        32'h8C010004, 0,  0, 0, 0, 32'h8C010004};
    vt[1] = '{1, 32'h44, 1, 1, 32'h10,  32'hDEADBEEF, 32'h11111111, 1,  0, 1, 0, 32'h0};
    vt[2] = '{1, 32'h44, 0, 0, 32'h0,   32'h0,        32'h12345678, 2,  0, 0, 0, 32'h12345678};
    vt[3] = '{0, 32'h0,  1, 0, 32'h200, 32'h0,        32'hA5A50F0F, 15, 0, 1, 0, 32'hA5A50F0F};
    vt[4] = '{0, 32'h0,  1, 0, 32'h204, 32'h0,        32'h77777777, 99, 0, 1, 1, 32'h0};
    vt[5] = '{0, 32'h0,  1, 0, 32'h208, 32'h0,        32'h0BADF00D, 3,  1, 1, 0, 32'h0BADF00D};
    vt[6] = '{1, 32'h48, 0, 0, 32'h0,   32'h0,        32'h33333333, 16, 0, 0, 1, 32'h0};
    vt[7] = '{1, 32'h4C, 1, 1, 32'h20C, 32'hCAFEF00D, 32'h44444444, 0,  0, 1, 0, 32'h0};

    if_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    reset = 1;
    step();
    do_reset();

    for (int i = 0; i < 8; i++) do_access(vt[i]);

    // Reset during WAIT abandons the access; a late ack is ignored.
    d_req = 1; d_we = 0; d_addr = 32'h80; mem_rdata = 32'h55AA55AA; mem_ack = 0;
    step();
    chk("rst_issue_mem_en", mem_en, 1);
    d_req = 0;
    repeat (3) step();
    reset = 1;
    step();
    reset = 0;
    check_quiet("rst_mid");
    mem_ack = 1;
    step();
    mem_ack = 0;
    check_quiet("stale_ack");
    repeat (3) begin
      step();
      chk("stale_no_ready", if_ready | d_ready | err | mem_en, 0);
    end
    streak_m = 0;

    // Both requesters held continuously: D,D,D,D,IF repeating.
    for (int i = 0; i < 10; i++) begin
      v = '{1, 32'h1000 + 32'(i * 4), 1, 0, 32'h2000 + 32'(i * 4), 32'h0,
            $urandom, int'($urandom_range(0, 2)), 0, (i % 5) != 4, 0, 32'h0};
      v.exp_rdata = v.mdata;
      do_access(v);
    end

    // Randomized accesses against the transaction-level model.
    for (int i = 0; i < 120; i++) begin
      v.ireq = 1'($urandom);
      v.dreq = 1'($urandom);
      if (!v.ireq && !v.dreq) v.dreq = 1;
      v.iaddr  = $urandom & 32'hFFFF_FFFC;
      v.daddr  = $urandom;
      v.dwe    = 1'($urandom);
      v.dwdata = $urandom;
      v.mdata  = $urandom;
      v.lat    = int'($urandom_range(0, 19));
      v.drop   = ($urandom_range(0, 7) == 0);
      v.exp_d  = v.dreq && !(v.ireq && streak_m == STREAK_MAX);
      v.exp_err = (v.lat > TIMEOUT);
      v.exp_rdata = (v.exp_err || (v.exp_d && v.dwe)) ? 32'h0 : v.mdata;
      do_access(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
